// File: rtl/e_cycle_ctrl.sv
// 6800-style E clock generator and synchronous peripheral cycle sequencer.
// Aligns VPA cycles to E, drives VMA_n and terminates the CPU cycle with DTACK_CPU_n.
`timescale 1ns/1ps

module e_cycle_ctrl #(
  parameter int E_PERIOD  = 10,
  parameter int E_HIGH    = 4,
  parameter int VMA_CNT   = 3,
  parameter int DTACK_CNT = 8
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       VPA_n,
  input  logic [2:0] FC,
  output logic       E,
  output logic       VMA_n,
  output logic       DTACK_CPU_n,
  output logic       BUSY
);

  localparam int CW = $clog2(E_PERIOD);
  localparam logic [CW-1:0] ECNT_LAST  = CW'(E_PERIOD - 1);
  localparam logic [CW-1:0] E_START    = CW'(E_PERIOD - E_HIGH);
  localparam logic [CW-1:0] VMA_AT     = CW'(VMA_CNT);
  localparam logic [CW-1:0] DTACK_AT   = CW'(DTACK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, VMA, TERM} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] ecnt;
  logic [CW-1:0] ecnt_nxt;
  logic          as_meta;
  logic          as_s;
  logic          vpa_meta;
  logic          vpa_s;
  logic [2:0]    fc_r;
  logic          vma_nxt;
  logic          dtack_nxt;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      as_meta  <= 1'b1;
      as_s     <= 1'b1;
      vpa_meta <= 1'b1;
      vpa_s    <= 1'b1;
    end else begin
      as_meta  <= AS_CPU_n;
      as_s     <= as_meta;
      vpa_meta <= VPA_n;
      vpa_s    <= vpa_meta;
    end
  end

  // E is registered from the next count so it lines up exactly with ecnt.
  assign ecnt_nxt = (ecnt == ECNT_LAST) ? '0 : ecnt + 1'b1;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      ecnt <= '0;
      E    <= 1'b0;
    end else begin
      ecnt <= ecnt_nxt;
      E    <= (ecnt_nxt >= E_START);
    end
  end

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      VMA_n       <= 1'b1;
      DTACK_CPU_n <= 1'b1;
      fc_r        <= 3'b000;
    end else begin
      state       <= state_nxt;
      VMA_n       <= vma_nxt;
      DTACK_CPU_n <= dtack_nxt;
      if (state == IDLE && state_nxt == SYNC) begin
        fc_r <= FC;
      end
    end
  end

  // Every path back to IDLE requires as_s high, so a held AS cannot re-trigger.
  always_comb begin
    state_nxt = state;
    vma_nxt   = VMA_n;
    dtack_nxt = DTACK_CPU_n;
    case (state)
      IDLE: begin
        vma_nxt   = 1'b1;
        dtack_nxt = 1'b1;
        if (!as_s && !vpa_s) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (as_s) begin
          state_nxt = IDLE;
          vma_nxt   = 1'b1;
          dtack_nxt = 1'b1;
        end else if (ecnt == VMA_AT) begin
          state_nxt = VMA;
          vma_nxt   = (fc_r == 3'b111);
        end
      end
      VMA: begin
        if (as_s) begin
          state_nxt = IDLE;
          vma_nxt   = 1'b1;
          dtack_nxt = 1'b1;
        end else if (ecnt == DTACK_AT) begin
          state_nxt = TERM;
          dtack_nxt = 1'b0;
        end
      end
      TERM: begin
        if (as_s) begin
          state_nxt = IDLE;
          vma_nxt   = 1'b1;
          dtack_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        vma_nxt   = 1'b1;
        dtack_nxt = 1'b1;
      end
    endcase
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_e_cycle_ctrl.sv
// Scoreboard bench for e_cycle_ctrl: directed requests push expected output edges,
// a negedge monitor pops them as VMA_n / DTACK_CPU_n / BUSY change and checks E phase.
`timescale 1ns/1ps

module tb_e_cycle_ctrl;

  logic       C7M;
  logic       RESET;
  logic       AS_CPU_n;
  logic       VPA_n;
  logic [2:0] FC;
  logic       E;
  logic       VMA_n;
  logic       DTACK_CPU_n;
  logic       BUSY;

  e_cycle_ctrl dut (
    .C7M         (C7M),
    .RESET       (RESET),
    .AS_CPU_n    (AS_CPU_n),
    .VPA_n       (VPA_n),
    .FC          (FC),
    .E           (E),
    .VMA_n       (VMA_n),
    .DTACK_CPU_n (DTACK_CPU_n),
    .BUSY        (BUSY)
  );

  localparam int SIG_VMA   = 0;
  localparam int SIG_DTACK = 1;
  localparam int SIG_BUSY  = 2;

  typedef struct {
    int   sig;
    logic val;
    int   cyc;
  } ev_t;

  ev_t   sb[$];
  string sig_name [3] = '{"VMA_n", "DTACK_CPU_n", "BUSY"};
  int    vectors = 0;
  int    errors  = 0;
  int    tcyc;
  logic  prev_vma;
  logic  prev_dtack;
  logic  prev_busy;

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  // Reference cycle count since reset release; tcyc % 10 is the expected E count.
  always @(posedge C7M or posedge RESET) begin
    if (RESET) tcyc <= 0;
    else       tcyc <= tcyc + 1;
  end

  task automatic expect_ev(input int sig, input logic val, input int cyc);
    ev_t e;
    e.sig = sig;
    e.val = val;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic check_direct(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_output(input int sig, input logic val);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s edge: got %b at cycle %0d, expected no change",
               sig_name[sig], val, tcyc);
    end else begin
      e = sb.pop_front();
      if (e.sig != sig || e.val !== val || e.cyc != tcyc) begin
        errors++;
        $display("[TB] FAIL event: got %s=%b at cycle %0d, expected %s=%b at cycle %0d",
                 sig_name[sig], val, tcyc, sig_name[e.sig], e.val, e.cyc);
      end
    end
  endtask

  // Simultaneous edges are always processed and queued in VMA_n, DTACK_CPU_n, BUSY order.
  always @(negedge C7M) begin
    if (RESET) begin
      prev_vma   = VMA_n;
      prev_dtack = DTACK_CPU_n;
      prev_busy  = BUSY;
    end else begin
      check_direct("E phase", E, ((tcyc % 10) >= 6));
      if (VMA_n !== prev_vma)       check_output(SIG_VMA, VMA_n);
      if (DTACK_CPU_n !== prev_dtack) check_output(SIG_DTACK, DTACK_CPU_n);
      if (BUSY !== prev_busy)       check_output(SIG_BUSY, BUSY);
      prev_vma   = VMA_n;
      prev_dtack = DTACK_CPU_n;
      prev_busy  = BUSY;
    end
  end

  task automatic wait_until(input int c);
    while (tcyc < c) @(negedge C7M);
  endtask

  task automatic wait_phase(input int p);
    do @(negedge C7M); while ((tcyc % 10) != p);
  endtask

  task automatic apply_stimulus(input logic [2:0] fc, input int phase, output int t);
    wait_phase(phase);
    t        = tcyc;
    FC       = fc;
    AS_CPU_n = 1'b0;
    VPA_n    = 1'b0;
  endtask

  task automatic release_bus();
    AS_CPU_n = 1'b1;
    VPA_n    = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check_direct("reset E", E, 1'b0);
    check_direct("reset VMA_n", VMA_n, 1'b1);
    check_direct("reset DTACK_CPU_n", DTACK_CPU_n, 1'b1);
    check_direct("reset BUSY", BUSY, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t;
    int r;
    RESET    = 1'b1;
    AS_CPU_n = 1'b1;
    VPA_n    = 1'b1;
    FC       = 3'b000;
    #1;
    check_reset_outputs();
    @(negedge C7M);
    @(negedge C7M);
    #2 RESET = 1'b0;

    $display("[TB] free-running E");
    wait_until(30);

    $display("[TB] request entering SYNC at ecnt=1");
    apply_stimulus(3'b101, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_VMA, 1'b0, t + 6);
    expect_ev(SIG_DTACK, 1'b0, t + 11);
    wait_until(t + 13);
    release_bus();
    r = t + 13;
    expect_ev(SIG_VMA, 1'b1, r + 3);
    expect_ev(SIG_DTACK, 1'b1, r + 3);
    expect_ev(SIG_BUSY, 1'b0, r + 3);
    wait_until(r + 6);

    $display("[TB] request entering SYNC at ecnt=5, VPA_n dropped early");
    apply_stimulus(3'b101, 2, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_VMA, 1'b0, t + 12);
    expect_ev(SIG_DTACK, 1'b0, t + 17);
    wait_until(t + 5);
    VPA_n = 1'b1;
    wait_until(t + 19);
    release_bus();
    r = t + 19;
    expect_ev(SIG_VMA, 1'b1, r + 3);
    expect_ev(SIG_DTACK, 1'b1, r + 3);
    expect_ev(SIG_BUSY, 1'b0, r + 3);
    wait_until(r + 6);

    $display("[TB] autovector cycle FC=111");
    apply_stimulus(3'b111, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_DTACK, 1'b0, t + 11);
    wait_until(t + 13);
    release_bus();
    r = t + 13;
    expect_ev(SIG_DTACK, 1'b1, r + 3);
    expect_ev(SIG_BUSY, 1'b0, r + 3);
    wait_until(r + 6);

    $display("[TB] abort during SYNC");
    apply_stimulus(3'b101, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    wait_until(t + 2);
    release_bus();
    expect_ev(SIG_BUSY, 1'b0, t + 5);
    wait_until(t + 14);

    $display("[TB] abort during VMA at ecnt=7");
    apply_stimulus(3'b101, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_VMA, 1'b0, t + 6);
    wait_until(t + 7);
    release_bus();
    expect_ev(SIG_VMA, 1'b1, t + 10);
    expect_ev(SIG_BUSY, 1'b0, t + 10);
    wait_until(t + 16);

    $display("[TB] reset mid-cycle");
    apply_stimulus(3'b101, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_VMA, 1'b0, t + 6);
    expect_ev(SIG_DTACK, 1'b0, t + 11);
    wait_until(t + 12);
    #2 RESET = 1'b1;
    release_bus();
    #1;
    check_reset_outputs();
    @(negedge C7M);
    @(negedge C7M);
    #2 RESET = 1'b0;

    $display("[TB] request after reset");
    apply_stimulus(3'b010, 8, t);
    expect_ev(SIG_BUSY, 1'b1, t + 3);
    expect_ev(SIG_VMA, 1'b0, t + 6);
    expect_ev(SIG_DTACK, 1'b0, t + 11);
    wait_until(t + 13);
    release_bus();
    r = t + 13;
    expect_ev(SIG_VMA, 1'b1, r + 3);
    expect_ev(SIG_DTACK, 1'b1, r + 3);
    expect_ev(SIG_BUSY, 1'b0, r + 3);
    wait_until(r + 8);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      vectors++;
      errors++;
      $display("[TB] FAIL missing %s: got no edge, expected %b at cycle %0d",
               sig_name[e.sig], e.val, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
